// File: rtl/prog_loader.sv
// Serial ICSP program loader feeding the PIC16C55 core program memory.
// Optional running write checksum and CLR_CSUM command: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int PC_WIDTH   = 9,
    parameter int INST_WIDTH = 12,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icspClk,
    input  logic                  icspData,
    input  logic                  icspEn,
    output logic                  memWrEn,
    output logic [PC_WIDTH-1:0]   memAddr,
    output logic [INST_WIDTH-1:0] memData,
    output logic                  coreRst_n,
    output logic                  busy,
    output logic                  errOut,
    output logic [INST_WIDTH-1:0] checksumOut
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_EXEC,
        S_RUN
    } state_t;

    localparam logic [3:0] CMD_LOAD = 4'h1;
    localparam logic [3:0] CMD_WR   = 4'h2;
    localparam logic [3:0] CMD_RUN  = 4'h3;
    localparam logic [3:0] CMD_CLR  = 4'h4;
    localparam logic [7:0] TO_CNT   = 8'(TIMEOUT);

    state_t state, next_state;

    logic clk_s1, clk_s2, clk_d;
    logic dat_s1, dat_s2;
    logic en_s1, en_s2, en_d;
    logic clk_rise, en_rise;

    logic [14:0]           shift_reg;
    logic [3:0]            bit_cnt;
    logic [7:0]            idle_cnt;
    logic [3:0]            cmd_reg;
    logic [PC_WIDTH-1:0]   pay_reg;
    logic [PC_WIDTH-1:0]   addr;
    logic [INST_WIDTH-1:0] data_reg;
    logic                  err;
    logic                  core_rst_n_q;
    logic                  busy_q;

    logic capture, last_bit, timeout, drop;
    logic is_load, is_wr, is_run, is_clr, is_bad;

    assign clk_rise = clk_s2 & ~clk_d;
    assign en_rise  = en_s2 & ~en_d;
    assign capture  = clk_rise &
                      ((state == S_SHIFT && en_s2) || state == S_EXEC);
    assign last_bit = capture && state == S_SHIFT && bit_cnt == 4'hF;
    assign drop     = state == S_SHIFT && !en_s2;
    assign timeout  = state == S_SHIFT && en_s2 && !clk_rise &&
                      idle_cnt == TO_CNT && bit_cnt != 4'h0;

    // Two-flop synchronizers plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b0;
            clk_s2 <= 1'b0;
            clk_d  <= 1'b0;
            dat_s1 <= 1'b0;
            dat_s2 <= 1'b0;
            en_s1  <= 1'b0;
            en_s2  <= 1'b0;
            en_d   <= 1'b0;
        end else begin
            clk_s1 <= icspClk;
            clk_s2 <= clk_s1;
            clk_d  <= clk_s2;
            dat_s1 <= icspData;
            dat_s2 <= dat_s1;
            en_s1  <= icspEn;
            en_s2  <= en_s1;
            en_d   <= en_s2;
        end
    end

    // Command decode of the last complete frame.
    always_comb begin
        is_load = 1'b0;
        is_wr   = 1'b0;
        is_run  = 1'b0;
        is_clr  = 1'b0;
        is_bad  = 1'b0;
        unique case (cmd_reg)
            CMD_LOAD: is_load = 1'b1;
            CMD_WR:   is_wr   = 1'b1;
            CMD_RUN:  is_run  = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            CMD_CLR:  is_clr  = 1'b1;
`else
            CMD_CLR:  is_bad  = 1'b1;
`endif
            default:  is_bad  = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  next_state = en_s2 ? S_SHIFT : S_RUN;
            S_SHIFT: begin
                if (!en_s2)        next_state = S_RUN;
                else if (last_bit) next_state = S_EXEC;
            end
            S_EXEC:  next_state = is_run ? S_RUN : S_SHIFT;
            S_RUN:   if (en_rise) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // FSM outputs: write strobe during EXEC of a WRITE frame.
    always_comb begin
        memWrEn = 1'b0;
        if (state == S_EXEC && is_wr) memWrEn = 1'b1;
    end

    // Registered core reset and busy, looked ahead from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            core_rst_n_q <= (next_state == S_RUN);
            busy_q       <= (next_state == S_SHIFT) ||
                            (next_state == S_EXEC);
        end
    end

    // Bit shifter, idle timer, frame latch, address and error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            cmd_reg   <= '0;
            pay_reg   <= '0;
            addr      <= '0;
            data_reg  <= '0;
            err       <= 1'b0;
        end else begin
            if (clk_rise)               idle_cnt <= '0;
            else if (idle_cnt != TO_CNT) idle_cnt <= idle_cnt + 8'd1;

            if (state == S_IDLE || state == S_RUN || drop || timeout) begin
                bit_cnt <= '0;
            end else if (capture) begin
                bit_cnt   <= bit_cnt + 4'd1;
                shift_reg <= {shift_reg[13:0], dat_s2};
            end

            if (last_bit) begin
                cmd_reg <= shift_reg[14:11];
                pay_reg <= {shift_reg[PC_WIDTH-2:0], dat_s2};
                if (shift_reg[14:11] == CMD_WR)
                    data_reg <= INST_WIDTH'({shift_reg[10:0], dat_s2});
            end

            if (state == S_EXEC) begin
                if (is_load) addr <= pay_reg;
                if (is_wr)   addr <= addr + PC_WIDTH'(1);
            end

            if (state == S_RUN && en_rise)
                err <= 1'b0;
            else if (timeout || (state == S_EXEC && is_bad))
                err <= 1'b1;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [INST_WIDTH-1:0] csum;

    // Running sum of written words, cleared by CLR_CSUM.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if (state == S_EXEC) begin
            if (is_wr)  csum <= csum + data_reg;
            if (is_clr) csum <= '0;
        end
    end

    assign checksumOut = csum;
`else
    assign checksumOut = '0;
`endif

    assign memAddr   = addr;
    assign memData   = data_reg;
    assign coreRst_n = core_rst_n_q;
    assign busy      = busy_q;
    assign errOut    = err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame table plus multi-cycle sequences.
// Build with or without PROG_LOADER_CHECKSUM_EN to match the RTL.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        icspClk = 1'b0;
    logic        icspData = 1'b0;
    logic        icspEn = 1'b0;
    logic        memWrEn;
    logic [8:0]  memAddr;
    logic [11:0] memData;
    logic        coreRst_n;
    logic        busy;
    logic        errOut;
    logic [11:0] checksumOut;

    int n_vec = 0;
    int n_bad = 0;

    logic [8:0]  wr_addr[$];
    logic [11:0] wr_data[$];
    bit          loading = 1'b0;
    int          busy_drop = 0;
    int          core_rel = 0;

    typedef struct {
        logic [15:0] frame;
        bit          wr;
        logic [8:0]  addr;
        logic [11:0] data;
        bit          err;
    } vec_t;

    vec_t tbl[8];

    prog_loader dut (
        .clk(clk),
        .rst(rst),
        .icspClk(icspClk),
        .icspData(icspData),
        .icspEn(icspEn),
        .memWrEn(memWrEn),
        .memAddr(memAddr),
        .memData(memData),
        .coreRst_n(coreRst_n),
        .busy(busy),
        .errOut(errOut),
        .checksumOut(checksumOut)
    );

    always #5 clk = ~clk;

    // Record every write strobe and watch busy/core reset while loading.
    always @(negedge clk) begin
        if (memWrEn === 1'b1) begin
            wr_addr.push_back(memAddr);
            wr_data.push_back(memData);
        end
        if (loading && busy !== 1'b1)      busy_drop++;
        if (loading && coreRst_n !== 1'b0) core_rel++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [15:0] f, input int n);
        for (int i = 15; i > 15 - n; i--) begin
            icspData = f[i];
            icspClk  = 1'b0;
            cyc(4);
            icspClk  = 1'b1;
            cyc(4);
        end
    endtask

    task automatic send_frame(input logic [15:0] f);
        send_bits(f, 16);
        cyc(2);
    endtask

    task automatic wait_sig(input string name, input int lim,
                            input bit want_core, input logic val);
        logic got;
        got = ~val;
        for (int i = 0; i < lim; i++) begin
            cyc(1);
            got = want_core ? coreRst_n : busy;
            if (got === val) break;
        end
        chk(name, {31'd0, got}, {31'd0, val});
    endtask

    task automatic reenter;
        icspEn = 1'b0;
        cyc(6);
        icspEn = 1'b1;
        wait_sig("reenter_busy", 10, 1'b0, 1'b1);
    endtask

    int          nw;
    logic [11:0] cs_a, cs_b;

    initial begin
        tbl[0] = '{16'h1005, 1'b0, 9'h000, 12'h000, 1'b0};
        tbl[1] = '{16'h2ABC, 1'b1, 9'h005, 12'hABC, 1'b0};
        tbl[2] = '{16'h2123, 1'b1, 9'h006, 12'h123, 1'b0};
        tbl[3] = '{16'h11FF, 1'b0, 9'h000, 12'h000, 1'b0};
        tbl[4] = '{16'h2001, 1'b1, 9'h1FF, 12'h001, 1'b0};
        tbl[5] = '{16'h2002, 1'b1, 9'h000, 12'h002, 1'b0};
        tbl[6] = '{16'h7000, 1'b0, 9'h000, 12'h000, 1'b1};
        tbl[7] = '{16'h2321, 1'b1, 9'h001, 12'h321, 1'b1};

        cyc(3);
        chk("rst_core", {31'd0, coreRst_n}, 32'd0);
        chk("rst_wr", {31'd0, memWrEn}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, errOut}, 32'd0);
        chk("rst_addr", {23'd0, memAddr}, 32'd0);
        chk("rst_data", {20'd0, memData}, 32'd0);
        chk("rst_csum", {20'd0, checksumOut}, 32'd0);
        rst = 1'b0;
        wait_sig("run_release", 4, 1'b1, 1'b1);
        cyc(10);
        chk("no_wr_idle", wr_addr.size(), 32'd0);

        icspEn = 1'b1;
        wait_sig("shift_busy", 10, 1'b0, 1'b1);
        chk("shift_core", {31'd0, coreRst_n}, 32'd0);
        loading = 1'b1;

        for (int v = 0; v < 8; v++) begin
            nw = wr_addr.size();
            send_frame(tbl[v].frame);
            chk($sformatf("v%0d_nwr", v), wr_addr.size(), nw + int'(tbl[v].wr));
            if (tbl[v].wr && wr_addr.size() > nw) begin
                chk($sformatf("v%0d_addr", v), {23'd0, wr_addr[nw]},
                    {23'd0, tbl[v].addr});
                chk($sformatf("v%0d_data", v), {20'd0, wr_data[nw]},
                    {20'd0, tbl[v].data});
            end
            chk($sformatf("v%0d_err", v), {31'd0, errOut},
                {31'd0, tbl[v].err});
        end
        loading = 1'b0;
        chk("busy_held", busy_drop, 32'd0);
        chk("core_held", core_rel, 32'd0);

        send_frame(16'h3000);
        chk("run_core", {31'd0, coreRst_n}, 32'd1);
        chk("run_busy", {31'd0, busy}, 32'd0);
        reenter();
        chk("idle_err_clr", {31'd0, errOut}, 32'd0);
        chk("reenter_core", {31'd0, coreRst_n}, 32'd0);

        nw = wr_addr.size();
        send_bits(16'h2055, 8);
        cyc(300);
        chk("to_err", {31'd0, errOut}, 32'd1);
        chk("to_nwr", wr_addr.size(), nw);
        send_frame(16'h2055);
        chk("to_after_nwr", wr_addr.size(), nw + 1);
        if (wr_addr.size() > nw) begin
            chk("to_after_addr", {23'd0, wr_addr[nw]}, 32'h002);
            chk("to_after_data", {20'd0, wr_data[nw]}, 32'h055);
        end

        icspEn = 1'b0;
        cyc(6);
        chk("en_drop_core", {31'd0, coreRst_n}, 32'd1);
        icspEn = 1'b1;
        wait_sig("cs_busy", 10, 1'b0, 1'b1);
        chk("cs_err0", {31'd0, errOut}, 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        cs_a = 12'h001;
`else
        cs_a = 12'h000;
`endif
        cs_b = 12'h000;
        nw = wr_addr.size();
        send_frame(16'h4000);
        chk("clr0_csum", {20'd0, checksumOut}, 32'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
        chk("clr0_err", {31'd0, errOut}, 32'd0);
`else
        chk("clr0_err", {31'd0, errOut}, 32'd1);
`endif
        send_frame(16'h2FFF);
        send_frame(16'h2002);
        chk("cs_sum", {20'd0, checksumOut}, {20'd0, cs_a});
        chk("cs_nwr", wr_addr.size(), nw + 2);
        send_frame(16'h4000);
        chk("cs_clr", {20'd0, checksumOut}, {20'd0, cs_b});
        chk("cs_clr_nwr", wr_addr.size(), nw + 2);

        nw = wr_addr.size();
        send_bits(16'h2777, 8);
        rst = 1'b1;
        cyc(2);
        chk("mid_rst_core", {31'd0, coreRst_n}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_addr", {23'd0, memAddr}, 32'd0);
        rst = 1'b0;
        cyc(20);
        chk("mid_rst_nwr", wr_addr.size(), nw);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
